// File: rtl/pio_result_arbiter.sv
// pio_result_arbiter: round-robin grant of NN result producers onto one 24-bit HPS PIO word,
// held until the HPS returns the word's seq bit on ack_tog or the wait times out.
module pio_result_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [16*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   ack_tog,
    input  logic                   clr_err,
    output logic [23:0]            pio_word,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [15:0]            grant_cnt
);
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [15:0] WCNT_LAST = 16'(TIMEOUT_CYC - 1);

    logic [0:0]  state;
    logic        seq;
    logic        ack_m;
    logic        ack_s;
    logic [5:0]  last_grant;
    logic [15:0] wcnt;
    logic        found;
    logic [5:0]  g;
    logic [15:0] g_data;
    logic [15:0] data_arr [NUM_REQ];
    int          idx;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[16*i +: 16];
    end

    // Scan from the farthest candidate back to the nearest so the nearest set bit after last_grant wins.
    always_comb begin
        found  = 1'b0;
        g      = last_grant;
        g_data = '0;
        idx    = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_grant) + k - ((int'(last_grant) + k >= NUM_REQ) ? NUM_REQ : 0);
            if (req_valid[IW'(idx)]) begin
                found  = 1'b1;
                g      = 6'(idx);
                g_data = data_arr[IW'(idx)];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            seq         <= 1'b0;
            ack_m       <= 1'b0;
            ack_s       <= 1'b0;
            last_grant  <= 6'(NUM_REQ - 1);
            wcnt        <= '0;
            pio_word    <= '0;
            req_ready   <= '0;
            timeout_err <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            ack_m     <= ack_tog;
            ack_s     <= ack_m;
            req_ready <= '0;
            if (clr_err)
                timeout_err <= 1'b0;
            if (state == IDLE) begin
                if (enable && found) begin
                    pio_word   <= {~seq, 1'b1, g, g_data};
                    seq        <= ~seq;
                    last_grant <= g;
                    req_ready  <= NUM_REQ'(1) << g;
                    grant_cnt  <= grant_cnt + 16'd1;
                    wcnt       <= '0;
                    state      <= WAIT_ACK;
                end
            end else if (ack_s == seq) begin
                pio_word[22] <= 1'b0;
                state        <= IDLE;
            end else if (TIMEOUT_CYC != 0 && wcnt == WCNT_LAST) begin
                // A timeout on the same edge as clr_err must leave the flag set.
                timeout_err  <= 1'b1;
                pio_word[22] <= 1'b0;
                state        <= IDLE;
            end else begin
                wcnt <= wcnt + 16'd1;
            end
        end
    end

    assign busy = state == WAIT_ACK;
endmodule

// File: tb/tb_pio_result_arbiter.sv
// tb_pio_result_arbiter: directed and randomized checks of pio_result_arbiter against a
// timestamp-based reference model of grants, acks (via ack history) and timeouts.
module tb_pio_result_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             enable = 1'b0;
    logic             ack_tog = 1'b0;
    logic             clr_err = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [16*N-1:0]  req_data = '0;
    logic [N-1:0]     req_ready;
    logic [23:0]      pio_word;
    logic             busy;
    logic             timeout_err;
    logic [15:0]      grant_cnt;

    pio_result_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .ack_tog(ack_tog), .clr_err(clr_err),
        .pio_word(pio_word), .busy(busy), .timeout_err(timeout_err), .grant_cnt(grant_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int rst_edge = 0;
    bit ack_at [$];
    bit m_busy, m_seq, m_err;
    int m_last, m_g_edge;
    logic [23:0] m_word;
    logic [15:0] m_cnt;
    logic [N-1:0] m_ready;
    bit hps_on = 0;
    bit hps_last = 0;
    int hps_wait = -1;
    int hps_max = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_pio_word", pio_word, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_grant_cnt", grant_cnt, 0);
        ack_tog = 1'b0;
        repeat (2) begin
            ack_at.push_back(ack_tog);
            @(posedge clk);
            n++;
        end
        #1;
        reset_n  = 1'b1;
        rst_edge = n;
        m_busy = 0; m_seq = 0; m_err = 0; m_last = N - 1; m_word = '0; m_cnt = '0; m_ready = '0;
        hps_last = 0; hps_wait = -1;
    endtask

    // One clock: snapshot inputs at the edge, advance the model, compare every output.
    task automatic step();
        logic [N-1:0] v;
        logic [15:0] d [N];
        bit en, clr, tout, a;
        int gi;
        v = req_valid; en = enable; clr = clr_err;
        for (int i = 0; i < N; i++) d[i] = req_data[16*i +: 16];
        ack_at.push_back(ack_tog);
        @(posedge clk);
        n++;
        #1;
        tout = 0;
        m_ready = '0;
        if (!m_busy) begin
            if (en && v != 0) begin
                gi = -1;
                for (int k = 1; k <= N; k++)
                    if (gi < 0 && v[(m_last + k) % N]) gi = (m_last + k) % N;
                m_seq = !m_seq;
                m_last = gi;
                m_word = {m_seq, 1'b1, 6'(gi), d[gi]};
                m_ready[gi] = 1'b1;
                m_cnt = m_cnt + 16'd1;
                m_busy = 1;
                m_g_edge = n;
            end
        end else begin
            a = (n - 2 > rst_edge) ? ack_at[n-2] : 1'b0;
            if (a == m_seq) begin
                m_busy = 0; m_word[22] = 1'b0;
            end else if (n - m_g_edge == TO) begin
                tout = 1; m_err = 1; m_busy = 0; m_word[22] = 1'b0;
            end
        end
        if (clr && !tout) m_err = 0;
        check("pio_word", pio_word, m_word);
        check("req_ready", req_ready, m_ready);
        check("busy", busy, m_busy);
        check("timeout_err", timeout_err, m_err);
        check("grant_cnt", grant_cnt, m_cnt);
        if (hps_on) begin
            if (hps_wait < 0 && m_word[22] && m_word[23] != hps_last) begin
                hps_last = m_word[23];
                hps_wait = $urandom_range(0, hps_max);
            end
            if (hps_wait == 0) begin
                ack_tog = hps_last;
                hps_wait = -1;
            end else if (hps_wait > 0) begin
                hps_wait--;
            end
        end
    endtask

    initial begin
        int got;
        int ord [5];
        bit sq [5];
        int exp_ord [5] = '{0, 1, 2, 3, 0};
        bit exp_sq [5] = '{1, 0, 1, 0, 1};
        ack_at.push_back(1'b0);
        do_reset();

        enable = 1'b1;
        req_data[2*16 +: 16] = 16'h1234;
        req_valid = 4'b0100;
        step();
        check("single_word", pio_word, 24'hC21234);
        check("single_ready", req_ready, 4'b0100);
        req_valid = '0;
        step();
        check("single_ready_pulse", req_ready, 0);
        ack_tog = 1'b1;
        repeat (3) step();
        check("single_ack_word", pio_word, 24'h821234);
        check("single_busy", busy, 0);

        do_reset();
        hps_on = 1; hps_max = 0;
        for (int i = 0; i < N; i++) req_data[16*i +: 16] = 16'(16'hA000 + i);
        req_valid = 4'hF;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            step();
            if (req_ready != 0) begin
                for (int i = 0; i < N; i++) if (req_ready[i]) ord[got] = i;
                sq[got] = pio_word[23];
                got++;
            end
        end
        check("rr_count", got, 5);
        check("rr_grant_cnt", grant_cnt, 5);
        for (int i = 0; i < 5; i++) begin
            check("rr_order", ord[i], exp_ord[i]);
            check("rr_seq", sq[i], exp_sq[i]);
        end
        req_valid = '0;
        repeat (6) step();

        do_reset();
        hps_on = 0;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (7) step();
        check("to_early", timeout_err, 0);
        step();
        check("to_err", timeout_err, 1);
        check("to_valid", pio_word[22], 0);
        req_valid = 4'b0010;
        step();
        check("to_next_seq", pio_word[23], 0);
        req_valid = '0;
        repeat (3) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("to_clr", timeout_err, 0);

        do_reset();
        enable = 1'b0;
        req_data[15:0] = 16'hBEEF;
        req_valid = 4'b0001;
        repeat (3) begin
            step();
            check("en_no_ready", req_ready, 0);
            check("en_no_word", pio_word, 0);
        end
        enable = 1'b1;
        step();
        check("en_ready", req_ready, 4'b0001);
        check("en_word", pio_word, 24'hC0BEEF);
        step();
        check("mid_busy", busy, 1);
        do_reset();
        step();
        check("rst_regrant", pio_word, 24'hC0BEEF);
        req_valid = '0;

        do_reset();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (5) step();
        ack_tog = 1'b1;
        repeat (3) step();
        check("coll_err", timeout_err, 0);
        check("coll_busy", busy, 0);
        check("coll_valid", pio_word[22], 0);

        do_reset();
        hps_on = 1; hps_max = 11;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[16*i +: 16] = 16'($urandom);
                end
            enable  = $urandom_range(0, 15) != 0;
            clr_err = $urandom_range(0, 31) == 0;
            if ($urandom_range(0, 999) == 0) do_reset();
            step();
            for (int i = 0; i < N; i++)
                if (m_ready[i]) begin
                    req_valid[i] = $urandom_range(0, 1) == 1;
                    req_data[16*i +: 16] = 16'($urandom);
                end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_result_arbiter.md
# pio_result_arbiter

Shares the single 24-bit HPS-readable PIO input port between NUM_REQ neural-network result producers. Each producer is typically an output-layer neuron or a layer-done reporter. The block grants producers round-robin and frames each result into one 24-bit word with a sequence bit, a valid bit and the channel index. It then holds that word until the HPS acknowledges it through a toggle bit written via an HPS output PIO. It sits between the MLP datapath and the PIO's in_port, and handles ack timeouts and status counting.

## Interface
- NUM_REQ, 4: number of requesters, range 2..64
- TIMEOUT_CYC, 65535: maximum clk cycles spent waiting for an ack; 0 disables the timeout
- clk  in  1  system clock, same clock as the PIO
- reset_n  in  1  reset; asynchronous, active-low
- enable  in  1  from HPS config; 0 blocks new grants, but the current transfer completes
- req_valid  in  NUM_REQ  per-requester result pending; must be held until req_ready is seen
- req_data  in  16*NUM_REQ  per-requester result; bits [16i+15:16i] belong to requester i
- req_ready  out  NUM_REQ  one-cycle pulse marking acceptance of requester i
- ack_tog  in  1  HPS acknowledge toggle from the output PIO; may be asynchronous
- clr_err  in  1  synchronous clear of timeout_err
- pio_word  out  24  drives PIO in_port: [23] seq, [22] valid, [21:16] channel index, [15:0] data
- busy  out  1  high while in WAIT_ACK
- timeout_err  out  1  sticky timeout flag
- grant_cnt  out  16  number of accepted results; wraps modulo 2^16

## Operation
- ack_tog passes through a 2-flop synchronizer to produce ack_s. The block has internal registers seq (1 bit), last_grant (6 bits) and a wait counter wcnt (16 bits).
- Reset values:
  - pio_word=0, req_ready=0, busy=0, timeout_err=0, grant_cnt=0
  - seq=0, last_grant=NUM_REQ-1, wcnt=0, synchronizer flops=0
  - state=IDLE
- State IDLE:
  - If enable=1 and any req_valid bit is set, pick g as the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - On that edge: pio_word<={~seq,1,g[5:0],req_data[g]}; seq<=~seq; last_grant<=g; req_ready[g]<=1; grant_cnt<=grant_cnt+1; wcnt<=0; go to WAIT_ACK.
  - Otherwise stay in IDLE; pio_word holds its value.
- State WAIT_ACK:
  - req_valid is ignored and req_ready=0 from the second WAIT_ACK cycle onward.
  - If ack_s==seq: pio_word[22]<=0, with the other bits held; go to IDLE.
  - Else if TIMEOUT_CYC!=0 and wcnt==TIMEOUT_CYC-1: timeout_err<=1; pio_word[22]<=0; go to IDLE. The result is dropped and the HPS resynchronizes from the seq bit.
  - Else wcnt<=wcnt+1.
- HPS protocol:
  - Poll until pio_word[22]=1 and pio_word[23] differs from the last seq seen.
  - Consume the word, then write ack_tog=pio_word[23].
- Ack priority: ack and timeout on the same edge resolves as ack; timeout_err is not set.
- clr_err and a new timeout on the same edge: the set wins.
- enable falling during WAIT_ACK does not abort; the block returns to IDLE normally and then stalls.
- Reset mid-transfer: all registers return to reset values. The requester's req_valid stays asserted and is re-granted after reset.
- A stale or duplicate ack (ack_s already equal to seq while in IDLE) has no effect.
- The requester drops req_valid or changes req_data only after sampling req_ready=1.

## Timing
- Grant latency: req_valid high at edge k while in IDLE gives pio_word and req_ready valid after edge k. req_ready stays high for exactly one cycle.
- Ack latency: an ack_tog change at edge a is detected at edge a+2 (synchronizer), returning to IDLE at a+3 at the latest. The next grant occurs on the following edge.
- Minimum time from one grant to the next is 4 cycles: 1 cycle in WAIT_ACK, 2 synchronizer cycles and 1 cycle in IDLE.
- Timeout fires after exactly TIMEOUT_CYC cycles in WAIT_ACK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Single request: NUM_REQ=4, req_valid=0b0100 with req_data[2]=0x1234. Required: pio_word=0xC21234 and req_ready=0b0100 for one cycle. Toggling ack_tog to 1 returns pio_word to 0x821234 within 3 cycles, with busy=0.
- Round-robin: all four requesters held valid, HPS model acknowledges each word. Grant order is 0,1,2,3,0. seq alternates 1,0,1,0,1. grant_cnt=5.
- Timeout: TIMEOUT_CYC=8, one request, no ack. After 8 WAIT_ACK cycles: timeout_err=1 and pio_word[22]=0. A second request then presents seq=0. Asserting clr_err clears timeout_err.
- Enable gating: enable=0 with req_valid=0b0001 produces no req_ready and pio_word=0. Raising enable produces a grant on the next edge.
- Reset mid-transfer: assert reset_n=0 while in WAIT_ACK. All outputs go to 0 asynchronously. After release, the still-valid requester is regranted with seq=1.
- Ack/timeout collision: ack arriving on the timeout edge leaves timeout_err=0 and the block returns to IDLE.
